// File: rtl/uart_bus_writer_if.sv
// Parallel bus between the writer and a 16550-style UART chip.
interface uart_bus_writer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
);
  logic [ADDR_W-1:0] uart_addr;
  logic [DATA_W-1:0] uart_dout;
  logic              uart_doe;
  logic [DATA_W-1:0] uart_din;
  logic              csn;
  logic              wrn;
  logic              rdn;

  // Writer side drives the bus and strobes; the UART returns read data.
  modport master (
    output uart_addr, uart_dout, uart_doe, csn, wrn, rdn,
    input  uart_din
  );

  modport slave (
    input  uart_addr, uart_dout, uart_doe, csn, wrn, rdn,
    output uart_din
  );
endinterface

// File: rtl/uart_bus_writer.sv
// Buffers bytes pushed on data_ready rising edges and drains them to an external UART,
// polling LSR.THRE before each burst and generating programmable csn/wrn/rdn timing.
module uart_bus_writer #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 2,
  parameter int unsigned THR_ADDR   = 0,
  parameter int unsigned LSR_ADDR   = 5,
  parameter int unsigned THRE_BIT   = 5,
  parameter int unsigned POLL_EN    = 1,
  parameter int unsigned BURST_LEN  = 16
) (
  input  logic                        clk_sample,
  input  logic                        rst,
  input  logic                        data_ready,
  input  logic [DATA_W-1:0]           din,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        fifo_full,
  output logic                        overflow,
  output logic                        busy,
  uart_bus_writer_if.master           bus
);

  localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned MAX_CYC = (SETUP_CYC > STROBE_CYC) ?
                                    ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                                    ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int unsigned BST_W   = $clog2(BURST_LEN + 1);

  localparam logic [CNT_W-1:0]  SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0]  STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0]  HOLD_LD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [ADDR_W-1:0] THR_A     = ADDR_W'(THR_ADDR);
  localparam logic [ADDR_W-1:0] LSR_A     = ADDR_W'(LSR_ADDR);
  localparam logic [BST_W-1:0]  BURST_MAX = BST_W'(BURST_LEN);
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);

  typedef enum logic [3:0] {
    StIdle, StRdSetup, StRdStrobe, StRdHold, StEval, StWrSetup, StWrStrobe, StWrHold, StGap
  } state_e;

  // FIFO storage and control
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_dr_d, r_ovf;
  logic              w_push_edge, w_push, w_pop, w_full, w_empty;

  // FSM and registered bus outputs
  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [BST_W-1:0]  r_burst;
  logic [DATA_W-1:0] r_lsr;
  logic              r_repoll;
  logic              r_csn, r_wrn, r_rdn, r_doe;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_dout;

  // Only THRE is consumed; the full LSR is kept for debug visibility.
  logic w_unused_lsr;
  assign w_unused_lsr = ^r_lsr;

  assign w_full      = (r_level == LVL_FULL);
  assign w_empty     = (r_level == '0);
  assign w_push_edge = data_ready & ~r_dr_d;
  // A pop in the same cycle frees a slot, so a push at full is still accepted.
  assign w_push      = w_push_edge & (~w_full | w_pop);

  // Pop happens on every entry into WrSetup.
  always_comb begin
    w_pop = 1'b0;
    unique case (r_state)
      StIdle:  w_pop = !w_empty && (POLL_EN == 0);
      StEval:  w_pop = r_lsr[THRE_BIT];
      StGap:   w_pop = !r_repoll && !w_empty && !((POLL_EN != 0) && (r_burst == BURST_MAX));
      default: w_pop = 1'b0;
    endcase
  end

  // FIFO storage write (no reset needed on data).
  always_ff @(posedge clk_sample) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  // Edge detect, pointers, level counter and sticky overflow.
  always_ff @(posedge clk_sample or posedge rst) begin
    if (rst) begin
      r_dr_d   <= 1'b0;
      r_ovf    <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      r_dr_d <= data_ready;
      if (w_push_edge && w_full && !w_pop) r_ovf <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Bus sequencer: each timed phase reloads r_cnt on entry and exits when it reaches zero.
  always_ff @(posedge clk_sample or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_burst  <= '0;
      r_lsr    <= '0;
      r_repoll <= 1'b0;
      r_csn    <= 1'b1;
      r_wrn    <= 1'b1;
      r_rdn    <= 1'b1;
      r_doe    <= 1'b0;
      r_addr   <= '0;
      r_dout   <= '0;
    end else begin
      if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      unique case (r_state)
        StIdle: begin
          if (!w_empty) begin
            r_burst <= '0;
            r_csn   <= 1'b0;
            r_cnt   <= SETUP_LD;
            if (w_pop) begin
              r_state <= StWrSetup;
              r_addr  <= THR_A;
              r_doe   <= 1'b1;
              r_dout  <= r_mem[r_rd_ptr];
            end else begin
              r_state <= StRdSetup;
              r_addr  <= LSR_A;
              r_doe   <= 1'b0;
            end
          end
        end
        StRdSetup: begin
          if (r_cnt == '0) begin
            r_state <= StRdStrobe;
            r_rdn   <= 1'b0;
            r_cnt   <= STROBE_LD;
          end
        end
        StRdStrobe: begin
          if (r_cnt == '0) begin
            r_lsr   <= bus.uart_din;
            r_state <= StRdHold;
            r_rdn   <= 1'b1;
            r_cnt   <= HOLD_LD;
          end
        end
        StRdHold: begin
          if (r_cnt == '0) begin
            r_state <= StEval;
            r_csn   <= 1'b1;
          end
        end
        StEval: begin
          if (w_pop) begin
            r_state <= StWrSetup;
            r_csn   <= 1'b0;
            r_cnt   <= SETUP_LD;
            r_addr  <= THR_A;
            r_doe   <= 1'b1;
            r_dout  <= r_mem[r_rd_ptr];
          end else begin
            r_state  <= StGap;
            r_repoll <= 1'b1;
          end
        end
        StWrSetup: begin
          if (r_cnt == '0) begin
            r_state <= StWrStrobe;
            r_wrn   <= 1'b0;
            r_cnt   <= STROBE_LD;
          end
        end
        StWrStrobe: begin
          if (r_cnt == '0) begin
            r_state <= StWrHold;
            r_wrn   <= 1'b1;
            r_cnt   <= HOLD_LD;
          end
        end
        StWrHold: begin
          if (r_cnt == '0) begin
            r_state  <= StGap;
            r_csn    <= 1'b1;
            r_doe    <= 1'b0;
            r_burst  <= r_burst + 1'b1;
            r_repoll <= 1'b0;
          end
        end
        StGap: begin
          r_repoll <= 1'b0;
          if (w_empty && !r_repoll) begin
            r_state <= StIdle;
          end else begin
            r_csn <= 1'b0;
            r_cnt <= SETUP_LD;
            if (r_burst == BURST_MAX) r_burst <= '0;
            if (w_pop) begin
              r_state <= StWrSetup;
              r_addr  <= THR_A;
              r_doe   <= 1'b1;
              r_dout  <= r_mem[r_rd_ptr];
            end else begin
              r_state <= StRdSetup;
              r_addr  <= LSR_A;
              r_doe   <= 1'b0;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign fifo_level    = r_level;
  assign fifo_full     = w_full;
  assign overflow      = r_ovf;
  assign busy          = (r_state != StIdle);
  assign bus.csn       = r_csn;
  assign bus.wrn       = r_wrn;
  assign bus.rdn       = r_rdn;
  assign bus.uart_doe  = r_doe;
  assign bus.uart_addr = r_addr;
  assign bus.uart_dout = r_dout;

endmodule

// File: tb/tb_uart_bus_writer.sv
// Directed bench for uart_bus_writer: UART LSR model, bus monitor and write log.
module tb_uart_bus_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic       data_ready;
  logic [7:0] din;
  logic [4:0] fifo_level;
  logic       fifo_full, overflow, busy;

  uart_bus_writer_if #(.DATA_W(8), .ADDR_W(3)) bus ();

  uart_bus_writer dut (
    .clk_sample (clk),
    .rst        (rst),
    .data_ready (data_ready),
    .din        (din),
    .fifo_level (fifo_level),
    .fifo_full  (fifo_full),
    .overflow   (overflow),
    .busy       (busy),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // LSR model: reads numbered above g_polls (since g_rd_base) return THRE=1.
  int mon_rd_cnt = 0;
  int g_rd_base  = 0;
  int g_polls    = 0;
  assign bus.uart_din = ((mon_rd_cnt - g_rd_base) > g_polls) ? 8'h20 : 8'h00;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
    logic       doe;
    int         len;
    int         pre;
    int         rds;
  } wr_rec_t;

  wr_rec_t mon_log[$];
  wr_rec_t cur;
  logic    p_wrn = 1'b1;
  logic    p_rdn = 1'b1;
  int      pre_cnt = 0;
  int      mon_rd_since = 0;
  int      mon_wr_starts = 0;
  int      mon_overlap = 0;

  // Bus monitor: logs each write with strobe width, setup length and preceding LSR reads.
  always @(negedge clk) begin
    p_wrn <= bus.wrn;
    p_rdn <= bus.rdn;
    if (!bus.wrn && !bus.rdn) mon_overlap <= mon_overlap + 1;
    if (!bus.rdn && p_rdn) begin
      mon_rd_cnt   <= mon_rd_cnt + 1;
      mon_rd_since <= mon_rd_since + 1;
    end
    if (!bus.wrn && p_wrn) begin
      mon_wr_starts <= mon_wr_starts + 1;
      cur.pre  <= pre_cnt;
      cur.len  <= 1;
      cur.addr <= bus.uart_addr;
      cur.data <= bus.uart_dout;
      cur.doe  <= bus.uart_doe;
      cur.rds  <= mon_rd_since;
    end else if (!bus.wrn) begin
      cur.len <= cur.len + 1;
    end
    if (bus.wrn && !p_wrn) begin
      mon_log.push_back(cur);
      mon_rd_since <= 0;
    end
    if (bus.csn) pre_cnt <= 0;
    else if (bus.wrn && bus.rdn) pre_cnt <= pre_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input int max_cyc);
    bool_done: begin
      repeat (3) @(posedge clk);
      for (int i = 0; i < max_cyc; i++) begin
        @(negedge clk);
        if (!busy && fifo_level == 0) disable bool_done;
      end
      check("wait_idle_timeout", 32'd1, 32'd0);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    din = b;
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0] din;
    int         polls;
    int         hold;
    logic [7:0] exp_dout;
    int         exp_reads;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int      base;
    int      starts;
    logic    quiet;
    wr_rec_t r;

    vecs[0] = '{din: 8'hA5, polls: 0, hold: 15, exp_dout: 8'hA5, exp_reads: 1};
    vecs[1] = '{din: 8'h3C, polls: 5, hold: 1,  exp_dout: 8'h3C, exp_reads: 6};
    vecs[2] = '{din: 8'hFF, polls: 1, hold: 3,  exp_dout: 8'hFF, exp_reads: 2};
    vecs[3] = '{din: 8'h00, polls: 0, hold: 1,  exp_dout: 8'h00, exp_reads: 1};
    vecs[4] = '{din: 8'h5A, polls: 2, hold: 40, exp_dout: 8'h5A, exp_reads: 3};

    rst = 1'b1;
    data_ready = 1'b0;
    din = 8'h00;
    repeat (10) @(negedge clk);
    check("rst_csn", {31'd0, bus.csn}, 32'd1);
    check("rst_wrn", {31'd0, bus.wrn}, 32'd1);
    check("rst_rdn", {31'd0, bus.rdn}, 32'd1);
    check("rst_doe", {31'd0, bus.uart_doe}, 32'd0);
    check("rst_addr", {29'd0, bus.uart_addr}, 32'd0);
    check("rst_dout", {24'd0, bus.uart_dout}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_level", {27'd0, fifo_level}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    rst = 1'b0;

    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!(bus.csn && bus.wrn && bus.rdn) || bus.uart_doe || busy || fifo_level != 0)
        quiet = 1'b0;
    end
    check("idle_quiet", {31'd0, quiet}, 32'd1);

    // Single-byte transfers with varying THRE poll counts and data_ready widths.
    for (int v = 0; v < 5; v++) begin
      base      = mon_log.size();
      g_rd_base = mon_rd_cnt;
      g_polls   = vecs[v].polls;
      @(negedge clk);
      din        = vecs[v].din;
      data_ready = 1'b1;
      repeat (vecs[v].hold) @(negedge clk);
      data_ready = 1'b0;
      wait_idle(600);
      check($sformatf("v%0d_nwrites", v), mon_log.size() - base, 32'd1);
      if (mon_log.size() == base + 1) begin
        r = mon_log[base];
        check($sformatf("v%0d_addr", v), {29'd0, r.addr}, 32'd0);
        check($sformatf("v%0d_dout", v), {24'd0, r.data}, {24'd0, vecs[v].exp_dout});
        check($sformatf("v%0d_doe", v), {31'd0, r.doe}, 32'd1);
        check($sformatf("v%0d_wrn_len", v), r.len, 32'd4);
        check($sformatf("v%0d_setup", v), r.pre, 32'd2);
        check($sformatf("v%0d_reads", v), r.rds, vecs[v].exp_reads);
      end
      check($sformatf("v%0d_level", v), {27'd0, fifo_level}, 32'd0);
    end

    // Fill past depth while THRE=0, then release: one poll, 16-byte burst in order.
    base      = mon_log.size();
    starts    = mon_wr_starts;
    g_rd_base = mon_rd_cnt;
    g_polls   = 1000;
    for (int i = 0; i < 20; i++) push_byte(8'(i));
    repeat (2) @(negedge clk);
    check("ovf_level", {27'd0, fifo_level}, 32'd16);
    check("ovf_full", {31'd0, fifo_full}, 32'd1);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    check("ovf_no_wrn", mon_wr_starts - starts, 32'd0);
    g_rd_base = mon_rd_cnt;
    g_polls   = 0;
    wait_idle(3000);
    check("burst_nwrites", mon_log.size() - base, 32'd16);
    if (mon_log.size() == base + 16) begin
      for (int i = 0; i < 16; i++) begin
        r = mon_log[base + i];
        check($sformatf("burst_data%0d", i), {24'd0, r.data}, i);
        check($sformatf("burst_rd%0d", i), {31'd0, r.rds != 0}, (i == 0) ? 32'd1 : 32'd0);
      end
    end
    check("burst_ovf_sticky", {31'd0, overflow}, 32'd1);

    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst2_ovf", {31'd0, overflow}, 32'd0);

    // Push at full on the exact cycle of a pop: byte accepted, no overflow.
    base      = mon_log.size();
    g_rd_base = mon_rd_cnt;
    g_polls   = 1000;
    for (int i = 0; i < 16; i++) push_byte(8'h40 + 8'(i));
    repeat (2) @(negedge clk);
    check("sim_pre_level", {27'd0, fifo_level}, 32'd16);
    g_rd_base = mon_rd_cnt;
    g_polls   = 0;
    begin : wait_rd
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (mon_rd_cnt - g_rd_base >= 1) disable wait_rd;
      end
      check("sim_rd_timeout", 32'd1, 32'd0);
    end
    begin : wait_eval
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (bus.csn) disable wait_eval;
      end
      check("sim_eval_timeout", 32'd1, 32'd0);
    end
    din        = 8'hEE;
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    check("sim_level", {27'd0, fifo_level}, 32'd16);
    check("sim_ovf", {31'd0, overflow}, 32'd0);
    wait_idle(3000);
    check("sim_nwrites", mon_log.size() - base, 32'd17);
    if (mon_log.size() == base + 17) begin
      for (int i = 0; i < 17; i++) begin
        r = mon_log[base + i];
        check($sformatf("sim_data%0d", i), {24'd0, r.data}, (i < 16) ? 32'h40 + i : 32'hEE);
      end
    end

    // Reset mid write strobe: strobes release immediately and nothing further happens.
    g_rd_base = mon_rd_cnt;
    g_polls   = 0;
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    begin : wait_wr
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (!bus.wrn) disable wait_wr;
      end
      check("rstw_timeout", 32'd1, 32'd0);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rstw_wrn", {31'd0, bus.wrn}, 32'd1);
    check("rstw_csn", {31'd0, bus.csn}, 32'd1);
    check("rstw_level", {27'd0, fifo_level}, 32'd0);
    starts = mon_wr_starts;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("rstw_no_strobe", mon_wr_starts - starts, 32'd0);
    check("rstw_busy", {31'd0, busy}, 32'd0);
    check("no_overlap", mon_overlap, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
